// File: rtl/vga_frame_monitor.sv
// Locks to a VGA hsync/vsync/color stream, recovers pixel coordinates, flags line and
// frame timing errors, captures a probe pixel and checksums the visible area of each frame.
module vga_frame_monitor #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int GOOD_LINES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] color_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        de,
    output logic [11:0] probe_color,
    output logic        probe_valid,
    output logic [15:0] frame_cnt,
    output logic [23:0] frame_sum,
    output logic        err_h,
    output logic        err_v
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_EDGE = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] V_EDGE = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam int TO_W = $clog2(2 * H_TOTAL + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(2 * H_TOTAL - 1);
    localparam int GC_W = $clog2(GOOD_LINES + 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GOOD_LINES - 1);
    localparam logic SA = SYNC_ACTIVE;

    typedef enum logic [1:0] {SEARCH, HCHK, VWAIT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             hs_q, hs_dly_q, vs_q, vs_dly_q;
    logic [11:0]      col_q;
    logic [9:0]       hc_q, hc_d, vc_q, vc_d;
    logic [GC_W-1:0]  good_q, good_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [23:0]      acc_q, acc_d;
    logic [9:0]       x_q, y_q;
    logic             de_q, de_d;
    logic [11:0]      pcol_q, pcol_d;
    logic             pvld_q, pvld_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [23:0]      fsum_q, fsum_d;
    logic             errh_q, errh_d, errv_q, errv_d;

    logic             hedge, vedge, hwrap, timeout, hc_bad, vc_bad, in_lock, frame_evt;
    logic [9:0]       hc_pred, vc_pred;

    assign hedge   = (hs_q == SA) && (hs_dly_q != SA);
    assign vedge   = (vs_q == SA) && (vs_dly_q != SA);
    assign hwrap   = !hedge && (hc_q == H_LAST);
    assign hc_pred = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    assign vc_pred = hwrap ? ((vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1) : vc_q;
    assign hc_bad  = hedge && (hc_pred != H_EDGE);
    assign vc_bad  = vedge && (vc_pred != V_EDGE);
    assign timeout = !hedge && (to_q == TO_LAST);
    assign in_lock = (state_q == LOCKED);

    // hc_d/vc_d are the coordinates of the pixel currently in the input register.
    always_comb begin
        hc_d    = hedge ? H_EDGE : hc_pred;
        vc_d    = vedge ? V_EDGE : vc_pred;
        state_d = state_q;
        good_d  = good_q;
        to_d    = hedge ? '0 : to_q + TO_W'(1);
        errh_d  = 1'b0;
        errv_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                to_d   = '0;
                good_d = '0;
                if (hedge) state_d = HCHK;
            end
            HCHK: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else if (hedge) begin
                    if (hc_bad) begin
                        good_d = '0;
                    end else if (good_q == GC_LAST) begin
                        good_d  = '0;
                        state_d = VWAIT;
                    end else begin
                        good_d = good_q + GC_W'(1);
                    end
                end
            end
            VWAIT: begin
                if (timeout)    state_d = SEARCH;
                else if (vedge) state_d = LOCKED;
            end
            LOCKED: begin
                errh_d = hc_bad || timeout;
                errv_d = vc_bad;
                if (errh_d || errv_d) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase

        frame_evt = in_lock && vedge && !errh_d && !errv_d;
        de_d      = in_lock && (hc_d < H_VIS) && (vc_d < V_VIS);
        pvld_d    = in_lock && (hc_d == probe_x) && (vc_d == probe_y);
        pcol_d    = pvld_d ? col_q : pcol_q;
        acc_d     = de_d ? acc_q + {12'd0, col_q} : acc_q;
        fsum_d    = fsum_q;
        fcnt_d    = fcnt_q;
        if (frame_evt) begin
            fsum_d = acc_q;
            fcnt_d = fcnt_q + 16'd1;
        end
        if (frame_evt || (state_q == VWAIT && state_d == LOCKED)) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q     <= ~SA;
            hs_dly_q <= ~SA;
            vs_q     <= ~SA;
            vs_dly_q <= ~SA;
            col_q    <= '0;
            state_q  <= SEARCH;
            hc_q     <= '0;
            vc_q     <= '0;
            good_q   <= '0;
            to_q     <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            de_q     <= 1'b0;
            pcol_q   <= '0;
            pvld_q   <= 1'b0;
            fcnt_q   <= '0;
            fsum_q   <= '0;
            errh_q   <= 1'b0;
            errv_q   <= 1'b0;
        end else begin
            hs_q     <= hsync;
            hs_dly_q <= hs_q;
            vs_q     <= vsync;
            vs_dly_q <= vs_q;
            col_q    <= color_in;
            state_q  <= state_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            good_q   <= good_d;
            to_q     <= to_d;
            acc_q    <= acc_d;
            x_q      <= hc_d;
            y_q      <= vc_d;
            de_q     <= de_d;
            pcol_q   <= pcol_d;
            pvld_q   <= pvld_d;
            fcnt_q   <= fcnt_d;
            fsum_q   <= fsum_d;
            errh_q   <= errh_d;
            errv_q   <= errv_d;
        end
    end

    assign locked      = in_lock;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign de          = de_q;
    assign probe_color = pcol_q;
    assign probe_valid = pvld_q;
    assign frame_cnt   = fcnt_q;
    assign frame_sum   = fsum_q;
    assign err_h       = errh_q;
    assign err_v       = errv_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a scaled-down raster (24x11 total, 16x6 visible).
module tb_vga_frame_monitor;
    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 1, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst, hsync, vsync;
    logic [11:0] color_in;
    logic [9:0]  probe_x, probe_y;
    logic        locked, de, probe_valid, err_h, err_v;
    logic [9:0]  x_pos, y_pos;
    logic [11:0] probe_color;
    logic [15:0] frame_cnt;
    logic [23:0] frame_sum;

    int checks = 0, errors = 0;
    int n_errh = 0, n_errv = 0, n_pv = 0;
    int gx = 0, gy = 0, vs_line = HV - HV + VV + VF;
    bit mode = 0, hs_kill = 0, short_line = 0;

    vga_frame_monitor #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .GOOD_LINES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .color_in(color_in),
        .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .x_pos(x_pos),
        .y_pos(y_pos), .de(de), .probe_color(probe_color), .probe_valid(probe_valid),
        .frame_cnt(frame_cnt), .frame_sum(frame_sum), .err_h(err_h), .err_v(err_v)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_h)       n_errh++;
        if (err_v)       n_errv++;
        if (probe_valid) n_pv++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".locked"}, 32'(locked), 0);
        chk({tag, ".x_pos"}, 32'(x_pos), 0);
        chk({tag, ".y_pos"}, 32'(y_pos), 0);
        chk({tag, ".de"}, 32'(de), 0);
        chk({tag, ".probe_color"}, 32'(probe_color), 0);
        chk({tag, ".probe_valid"}, 32'(probe_valid), 0);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, ".frame_sum"}, 32'(frame_sum), 0);
        chk({tag, ".err_h"}, 32'(err_h), 0);
        chk({tag, ".err_v"}, 32'(err_v), 0);
    endtask

    // Drives one pixel; returns after the negedge so DUT outputs (pixel two back) are settled.
    task automatic step();
        hsync    = (hs_kill || !(gx >= HV + HF && gx < HV + HF + HS)) ? 1'b1 : 1'b0;
        vsync    = (gy >= vs_line && gy < vs_line + VS) ? 1'b0 : 1'b1;
        color_in = mode ? {gx[3:0], gy[3:0], 4'h5} : 12'h001;
        @(posedge clk);
        #6;
        if (gx == HT - 1 || (short_line && gx == HT - 2)) begin
            gx = 0;
            short_line = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic run_to(input int x, input int y);
        for (int n = 0; n < 2 * FT; n++) begin
            if (gx == x && gy == y) break;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; color_in = '0;
        probe_x = 10'd10; probe_y = 10'd3;
        repeat (3) @(posedge clk);
        #6;
        chk_zero("reset");
        rst = 1'b0;

        // Initial lock: three hsync edges then the vsync edge at line 8.
        run_to(1, 8);
        chk("lock_before_vsync", 32'(locked), 0);
        step();
        chk("lock_after_vsync", 32'(locked), 1);
        chk("lock_x_pos", 32'(x_pos), 0);
        chk("lock_y_pos", 32'(y_pos), 8);
        chk("blank_de", 32'(de), 0);

        for (int f = 1; f <= 3; f++) begin
            repeat (FT) step();
            chk("const_frame_sum", 32'(frame_sum), 32'h60);
            chk("const_frame_cnt", 32'(frame_cnt), 32'(f));
        end
        chk("const_no_err_h", 32'(n_errh), 0);
        chk("const_no_err_v", 32'(n_errv), 0);

        // Coordinate-coded color with probe at (10,3) -> 12'hA35.
        mode = 1; n_pv = 0;
        repeat (2 * FT) step();
        chk("probe_pulses", 32'(n_pv), 2);
        chk("probe_color", 32'(probe_color), 32'hA35);
        chk("coded_frame_sum", 32'(frame_sum), 32'h2E0E0);
        chk("coded_frame_cnt", 32'(frame_cnt), 5);

        run_to(7, 1);
        chk("mid_x_pos", 32'(x_pos), 5);
        chk("mid_y_pos", 32'(y_pos), 1);
        chk("mid_de", 32'(de), 1);

        // Line 2 one pixel short: line 3 hsync edge arrives early.
        run_to(0, 2);
        short_line = 1;
        run_to(0, 4);
        chk("short_err_h", 32'(n_errh), 1);
        chk("short_unlocked", 32'(locked), 0);
        run_to(2, 8);
        chk("short_relock", 32'(locked), 1);
        chk("short_cnt_hold", 32'(frame_cnt), 5);

        mode = 0;
        repeat (FT) step();
        chk("post_relock_sum", 32'(frame_sum), 32'h60);
        chk("post_relock_cnt", 32'(frame_cnt), 6);

        // vsync one line early on a frame whose checksum would differ.
        mode = 1; vs_line = 7;
        run_to(0, 0);
        run_to(0, 9);
        chk("early_vs_err_v", 32'(n_errv), 1);
        chk("early_vs_unlocked", 32'(locked), 0);
        chk("early_vs_sum_hold", 32'(frame_sum), 32'h60);
        chk("early_vs_cnt_hold", 32'(frame_cnt), 6);
        chk("early_vs_no_err_h", 32'(n_errh), 1);
        vs_line = 8; mode = 0;
        run_to(2, 8);
        chk("early_vs_relock", 32'(locked), 1);

        // hsync stuck inactive: last edge at (18,7), timeout 48 cycles later at (18,9).
        hs_kill = 1;
        run_to(19, 9);
        chk("timeout_not_yet", 32'(n_errh), 1);
        chk("timeout_locked_yet", 32'(locked), 1);
        step();
        chk("timeout_err_h", 32'(n_errh), 2);
        chk("timeout_unlocked", 32'(locked), 0);
        hs_kill = 0;
        run_to(2, 8);
        chk("timeout_relock", 32'(locked), 1);

        // Reset mid-frame at (8,3).
        run_to(8, 3);
        rst = 1'b1;
        step();
        chk_zero("midrst");
        rst = 1'b0;
        run_to(0, 8);
        chk("midrst_not_locked", 32'(locked), 0);
        run_to(2, 8);
        chk("midrst_relock", 32'(locked), 1);
        chk("midrst_cnt", 32'(frame_cnt), 0);
        repeat (FT) step();
        chk("midrst_frame_cnt", 32'(frame_cnt), 1);
        chk("midrst_frame_sum", 32'(frame_sum), 32'h60);
        chk("final_err_h", 32'(n_errh), 2);
        chk("final_err_v", 32'(n_errv), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
